// File: rtl/spi_slave_regbank.sv
// SPI slave register bank: command word (R/W + start address) followed by an
// unlimited auto-incrementing data burst. Supports all CPOL/CPHA modes and either bit order.
//
// phase  | meaning
// CMD    | shifting in the command word, MISO carries DEVICE_ID
// RD     | MISO shifts regs[addr], MOSI ignored, addr advances per word
// WR     | MOSI words land in regs[addr] unless read-only, MISO echoes last word
module spi_slave_regbank #(
    parameter int                     NBITS     = 8,
    parameter int                     DEPTH     = 8,
    parameter int                     ADDR_W    = $clog2(DEPTH),
    parameter logic [DEPTH*NBITS-1:0] RESET_VAL = '0,
    parameter logic [DEPTH-1:0]       RO_MASK   = '0,
    parameter logic [NBITS-1:0]       DEVICE_ID = NBITS'(8'hA5)
) (
    input  logic                   sclk,
    input  logic                   reset,
    input  logic                   cs_n,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    input  logic                   cpol,
    input  logic                   cpha,
    input  logic                   lsb_first,
    output logic [DEPTH*NBITS-1:0] regs_q,
    output logic                   wr_strobe,
    output logic [ADDR_W-1:0]      wr_addr
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {PH_CMD, PH_RD, PH_WR} phase_t;

    phase_t             phase, phase_nxt;
    logic               clk_s, clk_l, frame_rst_b;
    logic [CNT_W-1:0]   bit_cnt, tx_idx;
    logic [NBITS-1:0]   rx_shift, rx_word, last_rx, tx_word;
    logic [ADDR_W-1:0]  addr;
    logic [NBITS-1:0]   regs [DEPTH];
    logic               word_done, wr_en, launched, miso_q, first_bit;

    // Mode selects which physical sclk edge acts as the sample edge; launch is the other one.
    assign clk_s       = sclk ^ cpol ^ cpha;
    assign clk_l       = ~clk_s;
    assign frame_rst_b = reset & ~cs_n;
    assign miso_oe     = frame_rst_b;

    assign word_done = (bit_cnt == CNT_W'(NBITS-1));
    assign rx_word   = lsb_first ? {mosi, rx_shift[NBITS-1:1]} : {rx_shift[NBITS-2:0], mosi};

    always_ff @(posedge clk_s or negedge frame_rst_b) begin
        if (!frame_rst_b) begin
            phase <= PH_CMD;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = phase;
        if (word_done && phase == PH_CMD) begin
            phase_nxt = rx_word[NBITS-1] ? PH_RD : PH_WR;
        end
    end

    always_comb begin
        wr_en   = 1'b0;
        tx_word = DEVICE_ID;
        case (phase)
            PH_RD: tx_word = regs[addr];
            PH_WR: begin
                tx_word = last_rx;
                wr_en   = word_done & ~RO_MASK[addr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_s or negedge frame_rst_b) begin
        if (!frame_rst_b) begin
            bit_cnt   <= '0;
            rx_shift  <= '0;
            addr      <= '0;
            last_rx   <= '0;
            wr_strobe <= 1'b0;
        end else begin
            rx_shift  <= rx_word;
            wr_strobe <= wr_en;
            if (word_done) begin
                bit_cnt <= '0;
                if (phase == PH_CMD) begin
                    addr <= rx_word[ADDR_W-1:0];
                end else begin
                    addr <= addr + 1'b1;
                end
                if (phase == PH_WR) begin
                    last_rx <= rx_word;
                end
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_s or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs[k] <= RESET_VAL[k*NBITS +: NBITS];
            end
            wr_addr <= '0;
        end else if (wr_en) begin
            regs[addr] <= rx_word;
            wr_addr    <= addr;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign regs_q[k*NBITS +: NBITS] = regs[k];
    end

    // Launch edges put out the bit for the next sample; sample k has not happened yet.
    assign tx_idx    = lsb_first ? bit_cnt : CNT_W'(NBITS-1) - bit_cnt;
    assign first_bit = lsb_first ? DEVICE_ID[0] : DEVICE_ID[NBITS-1];

    always_ff @(posedge clk_l or negedge frame_rst_b) begin
        if (!frame_rst_b) begin
            launched <= 1'b0;
        end else begin
            launched <= 1'b1;
        end
    end

    always_ff @(posedge clk_l or negedge reset) begin
        if (!reset) begin
            miso_q <= 1'b0;
        end else if (!cs_n) begin
            miso_q <= tx_word[tx_idx];
        end
    end

    // In cpha=0 the first bit must be valid before any launch edge has occurred.
    assign miso = (~launched & ~cpha & frame_rst_b) ? first_bit : miso_q;

endmodule
